// File: rtl/sw_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_pkg                                                                |
// | Shared symbol width, nucleotide codes and sequencer states.           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sw_pkg;

  localparam int SYM_W = 2;

  localparam logic [SYM_W-1:0] c_nt_a = 2'b00;
  localparam logic [SYM_W-1:0] c_nt_c = 2'b01;
  localparam logic [SYM_W-1:0] c_nt_g = 2'b10;
  localparam logic [SYM_W-1:0] c_nt_t = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/sw_max_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_max_tracker                                                        |
// | Best-score / best-column tracker on the last PE output of the chain.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sw_max_tracker #(
  parameter int SCORE_W = 10,
  parameter int POS_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               valid,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] max_score,
  output logic [POS_W-1:0]   max_pos
);

  logic [POS_W-1:0] r_pos;

  // Strict compare keeps the earliest column on ties; pos holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_pos     <= '0;
      max_score <= '0;
      max_pos   <= '0;
    end else if (valid) begin
      if (score > max_score) begin
        max_score <= score;
        max_pos   <= r_pos;
      end
      if (r_pos != {POS_W{1'b1}}) begin
        r_pos <= r_pos + POS_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sw_array_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_array_sequencer                                                    |
// | Loads a short read into a systolic PE chain, streams the reference,   |
// | drains the chain. Score tracking built only with SW_SCORE_TRACK_EN.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sw_array_sequencer
  import sw_pkg::*;
#(
  parameter int NUM_PE  = 8,
  parameter int SCORE_W = 10,
  parameter int POS_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               rd_valid,
  input  logic [SYM_W-1:0]   rd_sym,
  output logic               rd_ready,
  input  logic               ref_valid,
  input  logic [SYM_W-1:0]   ref_sym,
  input  logic               ref_last,
  output logic               ref_ready,
  output logic [SYM_W-1:0]   pe_S,
  output logic               pe_store_S,
  output logic [SYM_W-1:0]   pe_T,
  output logic               pe_init,
  input  logic [SCORE_W-1:0] pe_last_V,
  input  logic               pe_last_init,
  output logic [SCORE_W-1:0] max_score,
  output logic [POS_W-1:0]   max_pos
);

  localparam int c_cnt_w = $clog2(NUM_PE + 1);

  sw_state_e          r_state;
  sw_state_e          w_state_next;
  logic [c_cnt_w-1:0] r_load_cnt;
  logic [c_cnt_w-1:0] r_low_cnt;
  logic               r_err;
  logic               w_rd_accept;
  logic               w_ref_accept;
  logic               w_underrun;
  logic               w_clear;

  assign w_rd_accept  = (r_state == LOAD) && rd_valid;
  assign w_ref_accept = (r_state == STREAM) && ref_valid;
  assign w_underrun   = (r_state == STREAM) && !ref_valid;
  assign w_clear      = (r_state == IDLE) && start;

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign rd_ready  = (r_state == LOAD);
  assign ref_ready = (r_state == STREAM);
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The chain cannot stall, so a missing reference symbol ends the stream.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD;
      LOAD:    if (w_rd_accept && (r_load_cnt == c_cnt_w'(NUM_PE - 1))) w_state_next = STREAM;
      STREAM:  if (!ref_valid || ref_last) w_state_next = DRAIN;
      DRAIN:   if (!pe_last_init && (r_low_cnt == c_cnt_w'(NUM_PE))) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt <= '0;
      r_low_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_load_cnt <= '0;
      end else if (w_rd_accept) begin
        r_load_cnt <= r_load_cnt + c_cnt_w'(1);
      end
      // Counts consecutive idle cycles at the chain tail; NUM_PE+1 means empty.
      if ((r_state == DRAIN) && !pe_last_init) begin
        r_low_cnt <= r_low_cnt + c_cnt_w'(1);
      end else begin
        r_low_cnt <= '0;
      end
      if (w_clear) begin
        r_err <= 1'b0;
      end else if (w_underrun) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_S       <= '0;
      pe_store_S <= 1'b0;
      pe_T       <= '0;
      pe_init    <= 1'b0;
    end else begin
      pe_store_S <= w_rd_accept;
      pe_S       <= w_rd_accept ? rd_sym : '0;
      pe_init    <= w_ref_accept;
      pe_T       <= w_ref_accept ? ref_sym : '0;
    end
  end

`ifdef SW_SCORE_TRACK_EN
  sw_max_tracker #(
    .SCORE_W (SCORE_W),
    .POS_W   (POS_W)
  ) u_max_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_clear),
    .valid     (pe_last_init && busy),
    .score     (pe_last_V),
    .max_score (max_score),
    .max_pos   (max_pos)
  );
`else
  logic w_unused_score;
  assign w_unused_score = ^pe_last_V;
  assign max_score      = '0;
  assign max_pos        = '0;
`endif

endmodule
`default_nettype wire
